// File: rtl/alu_mc_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc_n_pkg
//  Brief    : Op codes, mul/div sequencer states and decode helpers for alu_mc_n.
//  Revision : 1.0  initial release
// ============================================================================
package alu_mc_n_pkg;

    localparam logic [3:0] c_op_sll   = 4'b0000;
    localparam logic [3:0] c_op_rsv0  = 4'b0001;
    localparam logic [3:0] c_op_srl   = 4'b0010;
    localparam logic [3:0] c_op_sra   = 4'b0011;
    localparam logic [3:0] c_op_mult  = 4'b0100;
    localparam logic [3:0] c_op_multu = 4'b0101;
    localparam logic [3:0] c_op_div   = 4'b0110;
    localparam logic [3:0] c_op_divu  = 4'b0111;
    localparam logic [3:0] c_op_add   = 4'b1000;
    localparam logic [3:0] c_op_slt   = 4'b1001;
    localparam logic [3:0] c_op_sub   = 4'b1010;
    localparam logic [3:0] c_op_sltu  = 4'b1011;
    localparam logic [3:0] c_op_and   = 4'b1100;
    localparam logic [3:0] c_op_or    = 4'b1101;
    localparam logic [3:0] c_op_xor   = 4'b1110;
    localparam logic [3:0] c_op_rsv1  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // Codes 01xx are the multi-cycle mul/div group.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return ~op[0];
    endfunction

endpackage : alu_mc_n_pkg
`default_nettype wire

// File: rtl/alu_mc_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc_n_if
//  Brief    : Request/response bundle between the EX-stage controller and alu_mc_n.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_mc_n_if #(
    parameter int WIDTH = 32
);
    localparam int SH_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SH_W-1:0]  shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, control, a, b, shamt,
        input  in_ready, out_valid, result, carry_out, overflow, zero,
               div_by_zero, hi, lo
    );

    modport slave (
        input  in_valid, control, a, b, shamt,
        output in_ready, out_valid, result, carry_out, overflow, zero,
               div_by_zero, hi, lo
    );

endinterface : alu_mc_n_if
`default_nettype wire

// File: rtl/alu_mc_n_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Brief    : Iterative shift-add multiplier / restoring divider on magnitudes,
//             with a final sign-fix cycle producing HI/LO.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_seq
    import alu_mc_n_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_start,
    input  wire logic             i_div,
    input  wire logic             i_signed,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [WIDTH-1:0]      o_hi,
    output logic [WIDTH-1:0]      o_lo,
    output logic                  o_div_zero
);
    localparam int              SH_W   = $clog2(WIDTH);
    localparam logic [SH_W-1:0] c_last = SH_W'(WIDTH - 1);

    md_state_t        r_state;
    logic [SH_W-1:0]  r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_a;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_a_mag = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Multiply: r_q holds the multiplier and shifts the product in from the top.
    assign w_mul_sum = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_div} : {(WIDTH+1){1'b0}});
    // Divide: partial remainder never reaches the divisor, so rem:bit fits WIDTH+1 bits.
    assign w_trial   = {r_rem, r_q[WIDTH-1]} - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_div      <= '0;
            r_a        <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a        <= i_a;
                        r_rem      <= '0;
                        r_q        <= w_a_mag;
                        r_div      <= w_b_mag;
                        r_is_div   <= i_div;
                        r_neg_q    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_neg_r    <= i_signed & i_a[WIDTH-1];
                        r_div_zero <= i_div & (i_b == '0);
                        r_count    <= '0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_is_div) begin
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {r_rem, r_q} <= {w_mul_sum, r_q[WIDTH-1:1]};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_prod     = {r_rem, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_q_fix    = r_neg_q ? -r_q : r_q;
    assign w_r_fix    = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        o_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            // Zero divisor reports the raw dividend rather than a sign-fixed remainder.
            if (r_div_zero) begin
                o_hi = r_a;
                o_lo = '1;
            end else begin
                o_hi = w_r_fix;
                o_lo = w_q_fix;
            end
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_FIX);
    assign o_div_zero = r_div_zero;

endmodule : muldiv_seq
`default_nettype wire

// File: rtl/alu_mc_n.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc_n
//  Brief    : Multi-cycle EX-stage ALU: single-cycle ALU ops plus iterative
//             mul/div writing HI/LO, behind a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc_n
    import alu_mc_n_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_mc_n_if.slave   bus
);
    localparam int MSB = WIDTH - 1;

    logic             w_accept;
    logic             w_is_md;
    logic             w_md_busy;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic             w_md_div_zero;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_known;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    assign w_is_md  = is_muldiv(bus.control);
    assign w_accept = bus.in_valid & bus.in_ready;

    muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv_seq (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_accept & w_is_md),
        .i_div      (is_div_op(bus.control)),
        .i_signed   (is_signed_op(bus.control)),
        .i_a        (bus.a),
        .i_b        (bus.b),
        .o_busy     (w_md_busy),
        .o_done     (w_md_done),
        .o_hi       (w_md_hi),
        .o_lo       (w_md_lo),
        .o_div_zero (w_md_div_zero)
    );

    assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_known = 1'b1;
        case (bus.control)
            c_op_add: begin
                w_res   = w_add[MSB:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (bus.a[MSB] == bus.b[MSB]) && (w_add[MSB] != bus.a[MSB]);
            end
            c_op_sub: begin
                // Bit WIDTH of the zero-extended difference is the borrow.
                w_res   = w_sub[MSB:0];
                w_carry = w_sub[WIDTH];
                w_ovf   = (bus.a[MSB] != bus.b[MSB]) && (w_sub[MSB] != bus.a[MSB]);
            end
            c_op_slt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            c_op_sltu: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            c_op_and:  w_res = bus.a & bus.b;
            c_op_or:   w_res = bus.a | bus.b;
            c_op_xor:  w_res = bus.a ^ bus.b;
            c_op_sll:  w_res = bus.b << bus.shamt;
            c_op_srl:  w_res = bus.b >> bus.shamt;
            c_op_sra:  w_res = $unsigned($signed(bus.b) >>> bus.shamt);
            default:   w_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_dbz       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_md_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_md_lo;
                r_carry     <= 1'b0;
                r_ovf       <= 1'b0;
                r_zero      <= (w_md_lo == '0);
                r_dbz       <= w_md_div_zero;
                r_hi        <= w_md_hi;
                r_lo        <= w_md_lo;
            end else if (w_accept && !w_is_md) begin
                // Reserved codes still answer, with every flag (zero included) low.
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_carry     <= w_carry;
                r_ovf       <= w_ovf;
                r_zero      <= w_known && (w_res == '0);
                r_dbz       <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = ~w_md_busy;
    assign bus.out_valid   = r_out_valid;
    assign bus.result      = r_result;
    assign bus.carry_out   = r_carry;
    assign bus.overflow    = r_ovf;
    assign bus.zero        = r_zero;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule : alu_mc_n
`default_nettype wire

// File: tb/tb_alu_mc_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mc_n
//  Brief    : Directed self-checking bench for alu_mc_n (WIDTH=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc_n;
    import alu_mc_n_pkg::*;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_mc_n_if #(.WIDTH(WIDTH)) bus ();

    alu_mc_n #(
        .WIDTH (WIDTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh);
        bus.in_valid = 1'b1;
        bus.control  = op;
        bus.a        = av;
        bus.b        = bv;
        bus.shamt    = sh;
    endtask

    task automatic do_single(input string tag, input logic [3:0] op, input logic [31:0] av,
                             input logic [31:0] bv, input logic [4:0] sh,
                             input logic [31:0] exp_res, input logic exp_c,
                             input logic exp_o, input logic exp_z);
        @(negedge clk);
        drive(op, av, bv, sh);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check_eq({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        check_eq({tag, "_carry"}, 64'(bus.carry_out), 64'(exp_c));
        check_eq({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_o));
        check_eq({tag, "_zero"}, 64'(bus.zero), 64'(exp_z));
        check_eq({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic do_md(input string tag, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz, input bit inject);
        int lat;
        bit ready_low;
        @(negedge clk);
        drive(op, av, bv, 5'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_low = (bus.in_ready === 1'b0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (inject && i == 5) drive(c_op_add, 32'd1, 32'd1, 5'd0);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                lat = i;
                break;
            end
            if (i <= 31 && bus.in_ready !== 1'b0) ready_low = 1'b0;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd33);
        check_eq({tag, "_busy"}, 64'(ready_low), 64'd1);
        check_eq({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check_eq({tag, "_result"}, 64'(bus.result), 64'(exp_lo));
        check_eq({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        check_eq({tag, "_flags"}, 64'({bus.carry_out, bus.overflow}), 64'd0);
        check_eq({tag, "_zero"}, 64'(bus.zero), 64'(exp_lo == 32'd0));
        check_eq({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        n_checks = 0;
        n_errors = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.control  = 4'd0;
        bus.a        = '0;
        bus.b        = '0;
        bus.shamt    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_result", 64'(bus.result), 64'd0);
        check_eq("rst_hilo", 64'({bus.hi, bus.lo}), 64'd0);
        check_eq("rst_flags", 64'({bus.carry_out, bus.overflow, bus.zero, bus.div_by_zero}), 64'd0);

        do_single("add_ovf",  c_op_add,  32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_single("add_cry",  c_op_add,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
        do_single("sub_brw",  c_op_sub,  32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        do_single("sub_ovf",  c_op_sub,  32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        do_single("slt",      c_op_slt,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0);
        do_single("sltu",     c_op_sltu, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        do_single("and",      c_op_and,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        do_single("or",       c_op_or,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        do_single("xor",      c_op_xor,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
        do_single("sll",      c_op_sll,  32'h1234, 32'h1, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        do_single("sra",      c_op_sra,  32'h1234, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        do_single("srl",      c_op_srl,  32'h1234, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        do_single("rsv0",     c_op_rsv0, 32'd5, 32'd5, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0);
        do_single("rsv1",     c_op_rsv1, 32'hFFFF_FFFF, 32'h1, 5'd1, 32'h0, 1'b0, 1'b0, 1'b0);

        // Back-to-back issue on consecutive edges.
        @(negedge clk);
        drive(c_op_add, 32'd1, 32'd2, 5'd0);
        @(posedge clk);
        #1;
        check_eq("b2b_first", 64'({bus.out_valid, bus.result}), {31'd0, 1'b1, 32'd3});
        drive(c_op_sub, 32'd10, 32'd4, 5'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_eq("b2b_second", 64'({bus.out_valid, bus.result}), {31'd0, 1'b1, 32'd6});

        do_md("mult",   c_op_mult,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
        do_single("add_keep_hilo", c_op_add, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0);
        check_eq("hilo_held", 64'({bus.hi, bus.lo}), 64'hFFFF_FFFF_FFFF_FFF1);
        do_md("multu",  c_op_multu, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_md("divu",   c_op_divu,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        do_md("div_neg", c_op_div,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_md("div_negb", c_op_div, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_md("div_min", c_op_div,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        do_md("div_zero", c_op_div, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
        do_md("divu_z", c_op_divu,  32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset in the middle of a multiply aborts it.
        @(negedge clk);
        drive(c_op_mult, 32'd3, 32'd4, 5'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_ready", 64'(bus.in_ready), 64'd1);
        check_eq("abort_hilo", 64'({bus.hi, bus.lo}), 64'd0);
        check_eq("abort_result", 64'(bus.result), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen = 1'b1;
        end
        check_eq("abort_quiet", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_mc_n
`default_nettype wire
